accum_differencer_8bit: RTL and testbench



---
 rtl/accum_pkg.sv | 9 +
 rtl/delta_skid_buffer.sv | 59 +++++
 rtl/accum_differencer_8bit.sv | 51 +++++
 tb/tb_accum_differencer_8bit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// accum_pkg: shared width, occupancy state and payload types for the accumulator differencer
package accum_pkg;
  localparam int ACC_WIDTH = 8;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;
  typedef struct packed {
    logic                 borrow;
    logic [ACC_WIDTH-1:0] delta;
  } payload_t;
endpackage

// File: rtl/delta_skid_buffer.sv
// delta_skid_buffer: 2-entry output queue with occupancy FSM and valid/ready handshakes
module delta_skid_buffer
  import accum_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           clear,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:0] out_data
);
  occ_t           state;
  logic [WIDTH:0] head;
  logic [WIDTH:0] tail;
  logic           accept;
  logic           consume;
  // in_ready depends only on registered state, so out_ready never reaches it
  assign in_ready  = (state != TWO) && !clear;
  assign out_valid = (state != EMPTY);
  assign out_data  = head;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else if (clear) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          head  <= in_data;
          state <= ONE;
        end
        ONE: if (accept && consume) begin
          head <= in_data;
        end else if (accept) begin
          tail  <= in_data;
          state <= TWO;
        end else if (consume) begin
          state <= EMPTY;
        end
        TWO: if (consume) begin
          head  <= tail;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: rtl/accum_differencer_8bit.sv
// accum_differencer_8bit: recovers per-step increments and wrap borrows from a running-sum stream
module accum_differencer_8bit
  import accum_pkg::*;
#(
  parameter int WIDTH     = ACC_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_delta,
  output logic                 out_borrow,
  output logic [CNT_WIDTH-1:0] sample_count
);
  logic [WIDTH-1:0] prev;
  logic [WIDTH:0]   result;
  logic [WIDTH:0]   head;
  logic             accept;
  assign accept = in_valid && in_ready;
  // borrow of the subtraction is exactly the accumulator's carry on that step
  assign result = {in_data < prev, in_data - prev};
  assign {out_borrow, out_delta} = head;
  delta_skid_buffer #(.WIDTH(WIDTH)) u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= '0;
      sample_count <= '0;
    end else if (clear) begin
      prev         <= '0;
      sample_count <= '0;
    end else if (accept) begin
      prev <= in_data;
      if (~&sample_count) sample_count <= sample_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_accum_differencer_8bit.sv
// tb_accum_differencer_8bit: directed and accumulator-model checks of the differencer
module tb_accum_differencer_8bit;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_delta;
  logic        out_borrow;
  logic [15:0] sample_count;
  int          vectors = 0;
  int          miscompares = 0;

  accum_differencer_8bit dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_delta    (out_delta),
    .out_borrow   (out_borrow),
    .sample_count (sample_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic b);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".delta"}, 32'(out_delta), 32'(d));
    chk({tag, ".borrow"}, 32'(out_borrow), 32'(b));
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] acc;
    logic [7:0] in1;
    logic [7:0] nacc;
    logic       ov;
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    chk_out("reset", 1'b0, 8'd0, 1'b0);
    chk("reset.count", 32'(sample_count), 0);
    reset_n = 1'b1;
    tick();
    chk("reset.in_ready", 32'(in_ready), 1);
    // streaming at full rate
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 8'd5;  tick(); chk_out("s5", 1'b1, 8'd5, 1'b0);
    in_data = 8'd12; tick(); chk_out("s12", 1'b1, 8'd7, 1'b0);
    in_data = 8'd12; tick(); chk_out("s12b", 1'b1, 8'd0, 1'b0);
    in_data = 8'd30; tick(); chk_out("s30", 1'b1, 8'd18, 1'b0);
    in_valid = 1'b0; tick();
    chk("drain.valid", 32'(out_valid), 0);
    chk("stream.count", 32'(sample_count), 4);
    // wrap-around
    in_valid = 1'b1;
    in_data = 8'd250; tick(); chk_out("w250", 1'b1, 8'd220, 1'b0);
    in_data = 8'd4;   tick(); chk_out("w4", 1'b1, 8'd10, 1'b1);
    in_data = 8'd3;   tick(); chk_out("w3", 1'b1, 8'd255, 1'b1);
    in_valid = 1'b0; tick();
    chk("wrap.count", 32'(sample_count), 7);
    // backpressure: fill both entries, third sample must wait
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'd10; tick(); chk_out("bp1", 1'b1, 8'd7, 1'b0);
    chk("bp1.in_ready", 32'(in_ready), 1);
    in_data = 8'd20; tick(); chk_out("bp2", 1'b1, 8'd7, 1'b0);
    chk("bp2.in_ready", 32'(in_ready), 0);
    in_data = 8'd25; tick(); chk_out("bp3", 1'b1, 8'd7, 1'b0);
    chk("bp3.in_ready", 32'(in_ready), 0);
    chk("bp3.count", 32'(sample_count), 9);
    out_ready = 1'b1;
    tick(); chk_out("bp4", 1'b1, 8'd10, 1'b0);
    chk("bp4.in_ready", 32'(in_ready), 1);
    tick(); chk_out("bp5", 1'b1, 8'd5, 1'b0);
    in_valid = 1'b0; tick();
    chk("bp.drain", 32'(out_valid), 0);
    chk("bp.count", 32'(sample_count), 10);
    // clear while full with a sample offered
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'd30; tick();
    in_data = 8'd40; tick();
    chk("pre_clear.in_ready", 32'(in_ready), 0);
    clear = 1'b1; in_data = 8'd77; out_ready = 1'b1;
    #1 chk("clear.in_ready", 32'(in_ready), 0);
    tick();
    clear = 1'b0;
    chk_out("clear", 1'b0, 8'd0, 1'b0);
    chk("clear.count", 32'(sample_count), 0);
    in_data = 8'd9; tick();
    chk_out("post_clear", 1'b1, 8'd9, 1'b0);
    chk("post_clear.count", 32'(sample_count), 1);
    // asynchronous reset while an output is pending
    in_valid = 1'b0; out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_out("areset", 1'b0, 8'd0, 1'b0);
    chk("areset.count", 32'(sample_count), 0);
    tick();
    reset_n = 1'b1;
    tick();
    // accumulator model feeding its running sum
    acc = '0; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in1 = 8'($urandom_range(0, 255));
      {ov, nacc} = {1'b0, acc} + {1'b0, in1};
      in_data = nacc;
      tick();
      chk("rand.delta", 32'(out_delta), 32'(in1));
      chk("rand.borrow", 32'(out_borrow), 32'(ov));
      acc = nacc;
    end
    in_valid = 1'b0; tick();
    chk("rand.count", 32'(sample_count), 1000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
